// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared decode types, opcodes and helper functions for the ID stage
// Purpose: opcode constants, packed control bundle, immediate-format enum,
//          imm_gen() and uses_rs() helpers used by the decode stage and hazard unit.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // All-zero value is the NOP bundle: no side effects anywhere downstream.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       lui;
        logic       m_ext;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;     // {alt (SUB/SRA), funct3}
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:                      imm_fmt = IMM_S;
            OPC_BRANCH:                     imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
            OPC_JAL:                        imm_fmt = IMM_J;
            default:                        imm_fmt = IMM_NONE;
        endcase
    endfunction

    // Returns the 32-bit sign-extended immediate; the opcode bits are not needed.
    function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm_gen = {ins[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_gen = 32'd0;
        endcase
    endfunction

    // {uses_rs2, uses_rs1}; unknown opcodes read nothing so they never stall.
    function automatic logic [1:0] uses_rs(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:  uses_rs = 2'b01;
            OPC_OP, OPC_STORE, OPC_BRANCH:   uses_rs = 2'b11;
            default:                         uses_rs = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - load-use detection and forwarding-source priority encoder
// Purpose: purely combinational hazard logic for the decode stage.
// Ports:
//   i_if_valid, i_rs1, i_rs2, i_uses_rs1, i_uses_rs2 : incoming instruction operands
//   i_ex_mem_read, i_ex_rd                            : load currently in EX
//   i_fwd_rd, i_fwd_we                                : forwarding sources, index 0 youngest
//   o_load_use                                        : stall request
//   o_fwd_sel1, o_fwd_sel2                            : 0 = regfile, i+1 = source i
module id_hazard_unit #(
    parameter int NUM_FWD = 2,
    localparam int SEL_W  = $clog2(NUM_FWD + 1)
)(
    input  logic                 i_if_valid,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic                 i_uses_rs1,
    input  logic                 i_uses_rs2,
    input  logic                 i_ex_mem_read,
    input  logic [4:0]           i_ex_rd,
    input  logic [5*NUM_FWD-1:0] i_fwd_rd,
    input  logic [NUM_FWD-1:0]   i_fwd_we,
    output logic                 o_load_use,
    output logic [SEL_W-1:0]     o_fwd_sel1,
    output logic [SEL_W-1:0]     o_fwd_sel2
);

    always_comb begin
        o_load_use = i_if_valid && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                     ((i_uses_rs1 && (i_rs1 == i_ex_rd)) ||
                      (i_uses_rs2 && (i_rs2 == i_ex_rd)));
    end

    // Scan oldest to youngest so the lowest matching index is written last and wins.
    always_comb begin
        o_fwd_sel1 = '0;
        o_fwd_sel2 = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_we[i] && (i_fwd_rd[5*i +: 5] != 5'd0)) begin
                if (i_uses_rs1 && (i_fwd_rd[5*i +: 5] == i_rs1)) begin
                    o_fwd_sel1 = SEL_W'(i + 1);
                end
                if (i_uses_rs2 && (i_fwd_rd[5*i +: 5] == i_rs2)) begin
                    o_fwd_sel2 = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - RV32IM decode stage with ID/EX register and hazard handling
// Purpose: decodes the IF word, reads the regfile combinationally, detects load-use
//          hazards, generates forwarding selects and registers the decoded bundle.
// Optional feature: define ID_PERF_CNT_EN to add the 32-bit o_id_stall_count port.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   IF side : i_if_valid, i_if_pc, i_if_instruction, o_id_ready
//   regfile : o_rf_rs1_addr, o_rf_rs2_addr, i_rf_rs1_data, i_rf_rs2_data
//   hazards : i_ex_mem_read, i_ex_rd, i_fwd_rd, i_fwd_we, i_flush
//   EX side : i_ex_ready, o_id_valid, o_id_pc, o_id_read_data1/2, o_id_immediate,
//             o_id_rs1, o_id_rs2, o_id_rd, o_id_func3, o_id_ctrl, o_id_fwd_sel1/2
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    localparam int SEL_W  = $clog2(NUM_FWD + 1)
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_if_valid,
    input  logic [XLEN-1:0]      i_if_pc,
    input  logic [31:0]          i_if_instruction,
    output logic                 o_id_ready,
    output logic [4:0]           o_rf_rs1_addr,
    output logic [4:0]           o_rf_rs2_addr,
    input  logic [XLEN-1:0]      i_rf_rs1_data,
    input  logic [XLEN-1:0]      i_rf_rs2_data,
    input  logic                 i_ex_mem_read,
    input  logic [4:0]           i_ex_rd,
    input  logic [5*NUM_FWD-1:0] i_fwd_rd,
    input  logic [NUM_FWD-1:0]   i_fwd_we,
    input  logic                 i_flush,
    input  logic                 i_ex_ready,
    output logic                 o_id_valid,
    output logic [XLEN-1:0]      o_id_pc,
    output logic [XLEN-1:0]      o_id_read_data1,
    output logic [XLEN-1:0]      o_id_read_data2,
    output logic [XLEN-1:0]      o_id_immediate,
    output logic [4:0]           o_id_rs1,
    output logic [4:0]           o_id_rs2,
    output logic [4:0]           o_id_rd,
    output logic [2:0]           o_id_func3,
    output logic [CTRL_W-1:0]    o_id_ctrl,
    output logic [SEL_W-1:0]     o_id_fwd_sel1,
    output logic [SEL_W-1:0]     o_id_fwd_sel2
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]          o_id_stall_count
`endif
);

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [1:0]       w_uses;
    logic             w_load_use;
    logic             w_advance;
    logic [SEL_W-1:0] w_sel1;
    logic [SEL_W-1:0] w_sel2;
    logic [31:0]      w_imm32;
    logic [4:0]       w_rd;
    ctrl_t            w_ctrl;

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_data1;
    logic [XLEN-1:0]  r_data2;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [2:0]       r_f3;
    ctrl_t            r_ctrl;
    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] r_sel2;

    assign w_opcode      = i_if_instruction[6:0];
    assign w_f3          = i_if_instruction[14:12];
    assign w_f7          = i_if_instruction[31:25];
    assign w_uses        = uses_rs(w_opcode);
    assign w_imm32       = imm_gen(i_if_instruction[31:7], imm_fmt(w_opcode));
    assign o_rf_rs1_addr = i_if_instruction[19:15];
    assign o_rf_rs2_addr = i_if_instruction[24:20];

    id_hazard_unit #(.NUM_FWD(NUM_FWD)) u_hazard (
        .i_if_valid    (i_if_valid),
        .i_rs1         (i_if_instruction[19:15]),
        .i_rs2         (i_if_instruction[24:20]),
        .i_uses_rs1    (w_uses[0]),
        .i_uses_rs2    (w_uses[1]),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_fwd_rd      (i_fwd_rd),
        .i_fwd_we      (i_fwd_we),
        .o_load_use    (w_load_use),
        .o_fwd_sel1    (w_sel1),
        .o_fwd_sel2    (w_sel2)
    );

    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.lui         = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.alu_src_pc  = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.jal         = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.alu_src_pc  = 1'b1;
                w_ctrl.wb_sel      = WB_PC4;
            end
            OPC_JALR: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.jalr        = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.wb_sel      = WB_PC4;
            end
            OPC_BRANCH: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.alu_op      = {1'b0, w_f3};
            end
            OPC_LOAD: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.wb_sel      = WB_MEM;
            end
            OPC_STORE: begin
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                // Only SRAI carries the alternate bit; ADDI etc. use imm[10] as data.
                w_ctrl.alu_op      = {(w_f3 == 3'b101) && w_f7[5], w_f3};
            end
            OPC_OP: begin
                if (w_f7 == 7'b0000001) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.m_ext     = 1'b1;
                    w_ctrl.alu_op    = {1'b0, w_f3};
                end else if ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000)) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = {w_f7[5], w_f3};
                end
            end
            default: ;
        endcase
    end

    // Non-writing instructions present rd=0 so no downstream comparator can match.
    assign w_rd = w_ctrl.reg_write ? i_if_instruction[11:7] : 5'd0;

    assign w_advance  = !r_valid || i_ex_ready;
    assign o_id_ready = w_advance && !w_load_use && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_f3    <= '0;
            r_ctrl  <= '0;
            r_sel1  <= '0;
            r_sel2  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_advance) begin
            if (i_if_valid && !w_load_use) begin
                r_valid <= 1'b1;
                r_pc    <= i_if_pc;
                r_data1 <= i_rf_rs1_data;
                r_data2 <= i_rf_rs2_data;
                r_imm   <= XLEN'($signed(w_imm32));
                r_rs1   <= i_if_instruction[19:15];
                r_rs2   <= i_if_instruction[24:20];
                r_rd    <= w_rd;
                r_f3    <= w_f3;
                r_ctrl  <= w_ctrl;
                r_sel1  <= w_sel1;
                r_sel2  <= w_sel2;
            end else begin
                // Bubble: IF word stays put and is re-evaluated next cycle.
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end
    end

    assign o_id_valid      = r_valid;
    assign o_id_pc         = r_pc;
    assign o_id_read_data1 = r_data1;
    assign o_id_read_data2 = r_data2;
    assign o_id_immediate  = r_imm;
    assign o_id_rs1        = r_rs1;
    assign o_id_rs2        = r_rs2;
    assign o_id_rd         = r_rd;
    assign o_id_func3      = r_f3;
    assign o_id_ctrl       = r_ctrl;
    assign o_id_fwd_sel1   = r_sel1;
    assign o_id_fwd_sel2   = r_sel2;

`ifdef ID_PERF_CNT_EN
    logic [31:0] r_stall_count;

    // Cycles lost to a flush are redirect cost, not stall cost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= 32'd0;
        end else if (!i_flush && (w_load_use || (r_valid && !i_ex_ready))) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_id_stall_count = r_stall_count;
`endif

endmodule
